greater_share_arb: RTL and testbench

- Round-robin arbiter/sequencer that time-shares one unsigned 7-bit "greater than" comparator (x_grtr_y = x > y) among NUM_REQ requesters in the ANC datapath, e.g. LMS step limiter, peak tracker and clip detector.
- The comparator is instantiated outside this block. This block drives its operands from registers and samples its combinational result.
- It returns each result to the requester that issued it through a two-stage issue/response pipeline. Throughput is one compare per cycle.

---
 rtl/greater_share_arb.sv | 102 ++++++++++
 tb/tb_greater_share_arb.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/greater_share_arb.sv
// greater_share_arb: round-robin sequencer that time-shares one external
// unsigned "x > y" comparator among NUM_REQ requesters. A grant in cycle N
// registers the winner's operands onto cmp_x/cmp_y. The comparator result
// is captured at the end of cycle N+1 and is presented in cycle N+2 with a
// one-hot rsp_valid and a binary rsp_id.
//
// Handshake: req is a level held with stable operands until gnt pulses.
// gnt is the accept strobe. The issue stage never stalls, so there is no
// ready/backpressure toward the requesters. rsp_valid is a one-cycle strobe
// with no ready, so the requester must take the result in that cycle.
module greater_share_arb #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 7,
    parameter int ID_W    = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] x_in,
    input  logic [NUM_REQ*WIDTH-1:0] y_in,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [WIDTH-1:0]         cmp_x,
    output logic [WIDTH-1:0]         cmp_y,
    input  logic                     cmp_x_grtr_y,
    output logic [NUM_REQ-1:0]       rsp_valid,
    output logic                     rsp_grtr,
    output logic [ID_W-1:0]          rsp_id
);

    localparam logic [ID_W-1:0] LAST_IDX = ID_W'(NUM_REQ - 1);

    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] cand;
    logic [ID_W-1:0] win_idx;
    logic [ID_W-1:0] ptr_next;
    logic            found;
    logic            grant;
    logic            iss_valid;
    logic [ID_W-1:0] iss_id;

    // Find the first asserted req, starting at ptr and wrapping modulo NUM_REQ.
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        cand    = ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req[cand]) begin
                found   = 1'b1;
                win_idx = cand;
            end
            cand = (cand == LAST_IDX) ? '0 : cand + 1'b1;
        end
    end

    // Qualify the winner with en, and keep gnt quiet while reset is held.
    // The winner's successor becomes the new head of the search.
    always_comb begin
        grant    = en && found && !rst;
        ptr_next = (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
        gnt      = '0;
        if (grant) begin
            gnt[win_idx] = 1'b1;
        end
    end

    // Issue stage: register the winner's operands, its id, and the new pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmp_x     <= '0;
            cmp_y     <= '0;
            iss_valid <= 1'b0;
            iss_id    <= '0;
            ptr       <= '0;
        end else begin
            iss_valid <= grant;
            if (grant) begin
                cmp_x  <= x_in[win_idx*WIDTH +: WIDTH];
                cmp_y  <= y_in[win_idx*WIDTH +: WIDTH];
                iss_id <= win_idx;
                ptr    <= ptr_next;
            end
        end
    end

    // Response stage: capture the comparator result and route it to the issuer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= '0;
            rsp_grtr  <= 1'b0;
            rsp_id    <= '0;
        end else begin
            rsp_valid <= '0;
            if (iss_valid) begin
                rsp_valid[iss_id] <= 1'b1;
                rsp_grtr          <= cmp_x_grtr_y;
                rsp_id            <= iss_id;
            end
        end
    end

endmodule

// File: tb/tb_greater_share_arb.sv
// Directed bench for greater_share_arb. The bench models the external
// comparator itself. Inputs change on the falling edge. Outputs are checked
// 1 time unit later, so a check in cycle c sees the grant for cycle c and
// the response for the grant made in cycle c-2.
module tb_greater_share_arb;

    localparam int N = 4;
    localparam int W = 7;

    logic           clk;
    logic           rst;
    logic           en;
    logic [N-1:0]   req;
    logic [N*W-1:0] x_in;
    logic [N*W-1:0] y_in;
    logic [N-1:0]   gnt;
    logic [W-1:0]   cmp_x;
    logic [W-1:0]   cmp_y;
    logic           cmp_x_grtr_y;
    logic [N-1:0]   rsp_valid;
    logic           rsp_grtr;
    logic [1:0]     rsp_id;

    int pass_cnt;
    int total_cnt;

    greater_share_arb #(.NUM_REQ(N), .WIDTH(W), .ID_W(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .req          (req),
        .x_in         (x_in),
        .y_in         (y_in),
        .gnt          (gnt),
        .cmp_x        (cmp_x),
        .cmp_y        (cmp_y),
        .cmp_x_grtr_y (cmp_x_grtr_y),
        .rsp_valid    (rsp_valid),
        .rsp_grtr     (rsp_grtr),
        .rsp_id       (rsp_id)
    );

    // External comparator model
    assign cmp_x_grtr_y = cmp_x > cmp_y;

    // Clock generation
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [1:0] oh2id(input logic [3:0] v);
        oh2id = '0;
        for (int i = 0; i < 4; i++) begin
            if (v[i]) oh2id = i[1:0];
        end
    endfunction

    task automatic set_op(input int i, input logic [W-1:0] x, input logic [W-1:0] y);
        x_in[i*W +: W] = x;
        y_in[i*W +: W] = y;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req = '0;
        #1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        en  = 1'b1;
        req = 4'b1111;
        x_in = '1;
        y_in = '0;
        #1;
        total_cnt++; if (gnt !== 4'b0000) $display("FAIL reset_gnt got %b want 0000", gnt); else pass_cnt++;
        total_cnt++; if (rsp_valid !== 4'b0000) $display("FAIL reset_rsp_valid got %b want 0000", rsp_valid); else pass_cnt++;
        total_cnt++; if (rsp_grtr !== 1'b0) $display("FAIL reset_rsp_grtr got %b want 0", rsp_grtr); else pass_cnt++;
        total_cnt++; if (rsp_id !== 2'd0) $display("FAIL reset_rsp_id got %0d want 0", rsp_id); else pass_cnt++;
        total_cnt++; if (cmp_x !== 7'd0) $display("FAIL reset_cmp_x got %0d want 0", cmp_x); else pass_cnt++;
        total_cnt++; if (cmp_y !== 7'd0) $display("FAIL reset_cmp_y got %0d want 0", cmp_y); else pass_cnt++;
        @(negedge clk);
        req  = '0;
        x_in = '0;
        y_in = '0;
        rst  = 1'b0;
    endtask

    // Requester 0 alone, granted every cycle; 12>12=0, 13>12=1, 0>0=0
    task automatic test_single();
        logic [3:0] t_req [0:5];
        logic [3:0] t_gnt [0:5];
        logic [3:0] t_rv  [0:5];
        logic       t_rg  [0:5];
        t_req = '{4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
        t_gnt = '{4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
        t_rv  = '{4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0000};
        t_rg  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            req = t_req[c];
            en  = 1'b1;
            if (c == 0) set_op(0, 7'd12, 7'd12);
            if (c == 1) set_op(0, 7'd13, 7'd12);
            if (c == 2) set_op(0, 7'd0, 7'd0);
            #1;
            total_cnt++; if (gnt !== t_gnt[c]) $display("FAIL single_gnt c%0d got %b want %b", c, gnt, t_gnt[c]); else pass_cnt++;
            total_cnt++; if (rsp_valid !== t_rv[c]) $display("FAIL single_rsp_valid c%0d got %b want %b", c, rsp_valid, t_rv[c]); else pass_cnt++;
            if (t_rv[c] != 4'b0000) begin
                total_cnt++; if (rsp_grtr !== t_rg[c]) $display("FAIL single_rsp_grtr c%0d got %b want %b", c, rsp_grtr, t_rg[c]); else pass_cnt++;
                total_cnt++; if (rsp_id !== oh2id(t_rv[c])) $display("FAIL single_rsp_id c%0d got %0d want %0d", c, rsp_id, oh2id(t_rv[c])); else pass_cnt++;
            end
        end
    endtask

    // All requesting for 8 cycles from pointer 1; x=13,y=12 everywhere
    task automatic test_all_req();
        logic [3:0] seq [0:7];
        logic [3:0] exp_g;
        logic [3:0] exp_rv;
        seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        for (int c = 0; c < 11; c++) begin
            @(negedge clk);
            req = (c < 8) ? 4'b1111 : 4'b0000;
            en  = 1'b1;
            if (c == 0) begin
                for (int i = 0; i < N; i++) set_op(i, 7'd13, 7'd12);
            end
            exp_g  = (c < 8) ? seq[c] : 4'b0000;
            exp_rv = (c >= 2 && c < 10) ? seq[c-2] : 4'b0000;
            #1;
            total_cnt++; if (gnt !== exp_g) $display("FAIL all_gnt c%0d got %b want %b", c, gnt, exp_g); else pass_cnt++;
            total_cnt++; if (rsp_valid !== exp_rv) $display("FAIL all_rsp_valid c%0d got %b want %b", c, rsp_valid, exp_rv); else pass_cnt++;
            if (exp_rv != 4'b0000) begin
                total_cnt++; if (rsp_grtr !== 1'b1) $display("FAIL all_rsp_grtr c%0d got %b want 1", c, rsp_grtr); else pass_cnt++;
                total_cnt++; if (rsp_id !== oh2id(exp_rv)) $display("FAIL all_rsp_id c%0d got %0d want %0d", c, rsp_id, oh2id(exp_rv)); else pass_cnt++;
            end
        end
    endtask

    // From pointer 0, req=0101: 1>12=0 then 15>12=1
    task automatic test_two_req();
        logic [3:0] t_req [0:4];
        logic [3:0] t_gnt [0:4];
        logic [3:0] t_rv  [0:4];
        logic       t_rg  [0:4];
        t_req = '{4'b0101, 4'b0101, 4'b0000, 4'b0000, 4'b0000};
        t_gnt = '{4'b0001, 4'b0100, 4'b0000, 4'b0000, 4'b0000};
        t_rv  = '{4'b0000, 4'b0000, 4'b0001, 4'b0100, 4'b0000};
        t_rg  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            req = t_req[c];
            en  = 1'b1;
            if (c == 0) begin
                set_op(0, 7'd1, 7'd12);
                set_op(2, 7'd15, 7'd12);
            end
            #1;
            total_cnt++; if (gnt !== t_gnt[c]) $display("FAIL two_gnt c%0d got %b want %b", c, gnt, t_gnt[c]); else pass_cnt++;
            total_cnt++; if (rsp_valid !== t_rv[c]) $display("FAIL two_rsp_valid c%0d got %b want %b", c, rsp_valid, t_rv[c]); else pass_cnt++;
            if (t_rv[c] != 4'b0000) begin
                total_cnt++; if (rsp_grtr !== t_rg[c]) $display("FAIL two_rsp_grtr c%0d got %b want %b", c, rsp_grtr, t_rg[c]); else pass_cnt++;
                total_cnt++; if (rsp_id !== oh2id(t_rv[c])) $display("FAIL two_rsp_id c%0d got %0d want %0d", c, rsp_id, oh2id(t_rv[c])); else pass_cnt++;
            end
        end
    endtask

    // en=0 blocks grants; first grant after enable is pointer 3; an
    // in-flight compare still completes after en falls (127>126=1)
    task automatic test_enable();
        logic       t_en  [0:6];
        logic [3:0] t_req [0:6];
        logic [3:0] t_gnt [0:6];
        logic [3:0] t_rv  [0:6];
        t_en  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        t_req = '{4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b0000};
        t_gnt = '{4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b0000, 4'b0000, 4'b0000};
        t_rv  = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b0000};
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            req = t_req[c];
            en  = t_en[c];
            if (c == 0) begin
                x_in = '0;
                y_in = '0;
                set_op(3, 7'd127, 7'd126);
            end
            #1;
            total_cnt++; if (gnt !== t_gnt[c]) $display("FAIL en_gnt c%0d got %b want %b", c, gnt, t_gnt[c]); else pass_cnt++;
            total_cnt++; if (rsp_valid !== t_rv[c]) $display("FAIL en_rsp_valid c%0d got %b want %b", c, rsp_valid, t_rv[c]); else pass_cnt++;
            if (t_rv[c] != 4'b0000) begin
                total_cnt++; if (rsp_grtr !== 1'b1) $display("FAIL en_rsp_grtr c%0d got %b want 1", c, rsp_grtr); else pass_cnt++;
                total_cnt++; if (rsp_id !== 2'd3) $display("FAIL en_rsp_id c%0d got %0d want 3", c, rsp_id); else pass_cnt++;
            end
        end
    endtask

    // Reset one cycle after granting requester 1 drops its result and pointer
    task automatic test_reset_mid();
        @(negedge clk);
        en  = 1'b1;
        req = 4'b0010;
        set_op(1, 7'd100, 7'd5);
        #1;
        total_cnt++; if (gnt !== 4'b0010) $display("FAIL rmid_gnt1 got %b want 0010", gnt); else pass_cnt++;
        @(negedge clk);
        rst = 1'b1;
        req = 4'b0000;
        #1;
        total_cnt++; if (rsp_valid !== 4'b0000) $display("FAIL rmid_rsp_in_rst got %b want 0000", rsp_valid); else pass_cnt++;
        total_cnt++; if (cmp_x !== 7'd0) $display("FAIL rmid_cmp_x got %0d want 0", cmp_x); else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        req = 4'b1111;
        set_op(0, 7'd20, 7'd30);
        #1;
        total_cnt++; if (rsp_valid !== 4'b0000) $display("FAIL rmid_rsp_dropped got %b want 0000", rsp_valid); else pass_cnt++;
        total_cnt++; if (gnt !== 4'b0001) $display("FAIL rmid_gnt_after got %b want 0001", gnt); else pass_cnt++;
        @(negedge clk);
        req = 4'b0000;
        #1;
        total_cnt++; if (rsp_valid !== 4'b0000) $display("FAIL rmid_rsp_gap got %b want 0000", rsp_valid); else pass_cnt++;
        @(negedge clk);
        #1;
        total_cnt++; if (rsp_valid !== 4'b0001) $display("FAIL rmid_rsp_valid got %b want 0001", rsp_valid); else pass_cnt++;
        total_cnt++; if (rsp_grtr !== 1'b0) $display("FAIL rmid_rsp_grtr got %b want 0", rsp_grtr); else pass_cnt++;
        total_cnt++; if (rsp_id !== 2'd0) $display("FAIL rmid_rsp_id got %0d want 0", rsp_id); else pass_cnt++;
    endtask

    // From pointer 1 with req=0111: (0,127)->0, (0,0)->0, (127,0)->1
    task automatic test_boundary();
        logic [3:0] t_req [0:5];
        logic [3:0] t_gnt [0:5];
        logic [3:0] t_rv  [0:5];
        logic       t_rg  [0:5];
        t_req = '{4'b0111, 4'b0111, 4'b0111, 4'b0000, 4'b0000, 4'b0000};
        t_gnt = '{4'b0010, 4'b0100, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
        t_rv  = '{4'b0000, 4'b0000, 4'b0010, 4'b0100, 4'b0001, 4'b0000};
        t_rg  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            req = t_req[c];
            en  = 1'b1;
            if (c == 0) begin
                set_op(0, 7'd127, 7'd0);
                set_op(1, 7'd0, 7'd127);
                set_op(2, 7'd0, 7'd0);
                set_op(3, 7'd0, 7'd0);
            end
            #1;
            total_cnt++; if (gnt !== t_gnt[c]) $display("FAIL bnd_gnt c%0d got %b want %b", c, gnt, t_gnt[c]); else pass_cnt++;
            total_cnt++; if (rsp_valid !== t_rv[c]) $display("FAIL bnd_rsp_valid c%0d got %b want %b", c, rsp_valid, t_rv[c]); else pass_cnt++;
            if (t_rv[c] != 4'b0000) begin
                total_cnt++; if (rsp_grtr !== t_rg[c]) $display("FAIL bnd_rsp_grtr c%0d got %b want %b", c, rsp_grtr, t_rg[c]); else pass_cnt++;
                total_cnt++; if (rsp_id !== oh2id(t_rv[c])) $display("FAIL bnd_rsp_id c%0d got %0d want %0d", c, rsp_id, oh2id(t_rv[c])); else pass_cnt++;
            end
        end
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        rst  = 1'b1;
        en   = 1'b0;
        req  = '0;
        x_in = '0;
        y_in = '0;
        test_reset();
        test_single();
        test_all_req();
        do_reset();
        test_two_req();
        test_enable();
        test_reset_mid();
        test_boundary();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
